// File: rtl/btn_speed_pkg.sv
// Shared types for the button-driven blink speed selector.
// Speed states and counter widths used by the tick and debounce logic.
package btn_speed_pkg;

  localparam int SPEED_W = 2;
  localparam int CNT_W   = 32;

  typedef enum logic [SPEED_W-1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } speed_e;

  function automatic speed_e next_speed(
    input speed_e s
  );
    speed_e n;
    n = S0;
    unique case (s)
      S0: n = S1;
      S1: n = S2;
      S2: n = S3;
      S3: n = S0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser plus counting debouncer for a bouncy input.
// rise_pulse marks the first cycle after the debounced level goes high.
module debounce
  import btn_speed_pkg::*;
#(
  parameter logic [31:0] CYCLES = 32'd500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout,
  output logic rise_pulse
);

  logic             s1;
  logic             s2;
  logic             dout_q;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      dout   <= 1'b0;
      dout_q <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1     <= din;
      s2     <= s1;
      dout_q <= dout;
      if (s2 == dout) begin
        db_cnt <= '0;
      end else if (db_cnt == CYCLES - 32'd1) begin
        dout   <= ~dout;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  assign rise_pulse = dout & ~dout_q;

endmodule

// File: rtl/btn_speed_tick.sv
// Debounced button steps through four blink speeds; emits a one-cycle
// tick every period+1 cycles at the selected speed.
module btn_speed_tick
  import btn_speed_pkg::*;
#(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd500000,
  parameter logic [31:0] PERIOD0         = 32'd16499999,
  parameter logic [31:0] PERIOD1         = 32'd6499999,
  parameter logic [31:0] PERIOD2         = 32'd3499999,
  parameter logic [31:0] PERIOD3         = 32'd1499999
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        btn,
  output logic        tick,
  output logic        btn_pressed,
  output logic [1:0]  speed_sel,
  output logic [31:0] period
);

  speed_e           state;
  logic [CNT_W-1:0] cnt;
  logic             db_level;
  logic             db_rise;
  logic             adv;

  debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_db (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .din       (btn),
    .dout      (db_level),
    .rise_pulse(db_rise)
  );

  assign adv       = db_rise & db_level;
  assign speed_sel = state;

  always_comb begin
    period = PERIOD0;
    unique case (1'b1)
      (state == S0): period = PERIOD0;
      (state == S1): period = PERIOD1;
      (state == S2): period = PERIOD2;
      (state == S3): period = PERIOD3;
    endcase
  end

  // A speed change restarts the count and drops any tick due that cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S0;
      btn_pressed <= 1'b0;
      tick        <= 1'b0;
      cnt         <= '0;
    end else if (adv) begin
      state       <= next_speed(state);
      btn_pressed <= 1'b1;
      tick        <= 1'b0;
      cnt         <= '0;
    end else begin
      btn_pressed <= 1'b0;
      if (cnt == period) begin
        cnt  <= '0;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt + 32'd1;
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_speed_tick.sv
// Bench for btn_speed_tick: cycle scoreboard plus phase table
// and hand-written corner sequences.
module tb_btn_speed_tick;

  localparam logic [31:0] DB = 32'd4;
  localparam logic [31:0] P0 = 32'd9;
  localparam logic [31:0] P1 = 32'd5;
  localparam logic [31:0] P2 = 32'd3;
  localparam logic [31:0] P3 = 32'd0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        btn = 1'b0;
  logic        tick;
  logic        btn_pressed;
  logic [1:0]  speed_sel;
  logic [31:0] period;

  always #5 CLK = ~CLK;

  btn_speed_tick #(
    .DEBOUNCE_CYCLES(DB),
    .PERIOD0(P0),
    .PERIOD1(P1),
    .PERIOD2(P2),
    .PERIOD3(P3)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .btn        (btn),
    .tick       (tick),
    .btn_pressed(btn_pressed),
    .speed_sel  (speed_sel),
    .period     (period)
  );

  typedef struct packed {
    logic        tk;
    logic        pr;
    logic [1:0]  sp;
    logic [31:0] pe;
  } obs_t;

  typedef struct {
    bit b;
    int len;
    int presses;
    int spd;
    int per;
    int ticks;
  } vec_t;

  obs_t sbq[$];
  int total = 0;
  int bad = 0;

  bit m_s1, m_s2, m_lvl, m_lvlq, m_tick, m_prs;
  int m_db, m_cnt, m_spd;
  int n_press, n_tick, cyc, last_press;

  function automatic int per_of(int s);
    case (s)
      0: return int'(P0);
      1: return int'(P1);
      2: return int'(P2);
      default: return int'(P3);
    endcase
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_lvlq = 0;
    m_tick = 0; m_prs = 0; m_db = 0; m_cnt = 0; m_spd = 0;
  endtask

  task automatic model_step();
    bit rise;
    int per;
    rise = m_lvl && !m_lvlq;
    per = per_of(m_spd);
    m_prs = rise;
    if (rise) begin
      m_spd = (m_spd + 1) % 4; m_cnt = 0; m_tick = 0;
    end else if (m_cnt == per) begin
      m_cnt = 0; m_tick = 1;
    end else begin
      m_cnt++; m_tick = 0;
    end
    m_lvlq = m_lvl;
    if (m_s2 != m_lvl) begin
      if (m_db == int'(DB) - 1) begin
        m_lvl = !m_lvl; m_db = 0;
      end else m_db++;
    end else m_db = 0;
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  task automatic step();
    obs_t e, g;
    model_step();
    sbq.push_back({m_tick, m_prs, 2'(m_spd), 32'(per_of(m_spd))});
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    g = {tick, btn_pressed, speed_sel, period};
    chk("sb", 64'(g), 64'(e));
    cyc++;
    if (btn_pressed) begin
      n_press++;
      last_press = cyc;
    end
    if (tick) n_tick++;
  endtask

  task automatic apply(bit b, int n);
    btn = b;
    repeat (n) step();
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N = 0;
    btn = 0;
    @(posedge CLK);
    #1;
    RST_N = 1;
    model_reset();
    cyc = 0; n_press = 0; n_tick = 0; last_press = 0;
  endtask

  initial begin
    vec_t tv[8];
    int first, after, k;
    tv[0] = '{1, 10, 1, 1, 5, -1};
    tv[1] = '{0, 10, 0, 1, 5, 2};
    tv[2] = '{1, 10, 1, 2, 3, -1};
    tv[3] = '{0, 10, 0, 2, 3, 3};
    tv[4] = '{1, 10, 1, 3, 0, -1};
    tv[5] = '{0, 10, 0, 3, 0, 10};
    tv[6] = '{1, 10, 1, 0, 9, -1};
    tv[7] = '{0, 10, 0, 0, 9, -1};

    model_reset();
    #1 RST_N = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_tick", 64'(tick), 0);
    chk("rst_prs", 64'(btn_pressed), 0);
    chk("rst_spd", 64'(speed_sel), 0);
    chk("rst_per", 64'(period), 64'(P0));
    RST_N = 1;
    cyc = 0; n_press = 0; n_tick = 0; last_press = 0;

    // idle: ticks every 10 cycles, first at cycle 10
    first = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick && first == 0) first = cyc;
    end
    chk("idle_first", 64'(first), 10);
    chk("idle_ticks", 64'(n_tick), 4);
    chk("idle_press", 64'(n_press), 0);
    chk("idle_spd", 64'(speed_sel), 0);
    chk("idle_per", 64'(period), 9);

    // bounce then stable high
    n_press = 0;
    btn = 1; step();
    btn = 0; step();
    btn = 1; step();
    btn = 0; step();
    btn = 1;
    cyc = 0; last_press = 0; first = 0; after = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (last_press != 0 && cyc > last_press && tick) begin
        after++;
        if (first == 0) first = cyc;
      end
    end
    chk("bnc_press", 64'(n_press), 1);
    chk("bnc_when", 64'(last_press), 7);
    chk("bnc_spd", 64'(speed_sel), 1);
    chk("bnc_first", 64'(first), 13);
    chk("bnc_ticks", 64'(after), 2);
    apply(0, 10);

    // four clean presses from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      n_press = 0;
      n_tick = 0;
      apply(tv[i].b, tv[i].len);
      chk($sformatf("tv%0d_prs", i), 64'(n_press), 64'(tv[i].presses));
      chk($sformatf("tv%0d_spd", i), 64'(speed_sel), 64'(tv[i].spd));
      chk($sformatf("tv%0d_per", i), 64'(period), 64'(tv[i].per));
      if (tv[i].ticks >= 0)
        chk($sformatf("tv%0d_tk", i), 64'(n_tick), 64'(tv[i].ticks));
    end

    // press lands on terminal count
    btn = 0;
    for (k = 0; k < 20 && m_cnt != 3; k++) step();
    chk("coin_align", 64'(k < 20), 1);
    btn = 1;
    repeat (6) step();
    chk("coin_pre_tk", 64'(tick), 0);
    step();
    chk("coin_prs", 64'(btn_pressed), 1);
    chk("coin_tk", 64'(tick), 0);
    chk("coin_spd", 64'(speed_sel), 1);
    n_tick = 0;
    repeat (5) step();
    chk("coin_gap", 64'(n_tick), 0);
    step();
    chk("coin_next", 64'(tick), 1);
    apply(0, 10);

    // async reset mid-count at speed 2
    apply(1, 10);
    apply(0, 10);
    chk("ar_spd2", 64'(speed_sel), 2);
    for (k = 0; k < 8 && !m_tick; k++) step();
    chk("ar_tick_pre", 64'(tick), 1);
    #2 RST_N = 0;
    #1;
    chk("ar_tick", 64'(tick), 0);
    chk("ar_prs", 64'(btn_pressed), 0);
    chk("ar_spd", 64'(speed_sel), 0);
    chk("ar_per", 64'(period), 64'(P0));
    @(posedge CLK);
    #1;
    chk("ar_hold", 64'({tick, speed_sel}), 0);
    #2 RST_N = 1;
    model_reset();
    cyc = 0; first = 0; n_press = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick && first == 0) first = cyc;
    end
    chk("ar_first", 64'(first), 10);

    // long hold, bouncy release
    n_press = 0;
    apply(1, 100);
    chk("hold_press", 64'(n_press), 1);
    chk("hold_spd", 64'(speed_sel), 1);
    n_press = 0;
    btn = 0; step();
    btn = 1; step();
    btn = 0; step();
    apply(0, 20);
    chk("rel_press", 64'(n_press), 0);
    chk("rel_spd", 64'(speed_sel), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
